imem_loadable: RTL and testbench

IMEM_LOADABLE -- requirements
Module: imem_loadable

---
 rtl/imem_loadable.sv | 113 +++++++++++
 tb/tb_imem_loadable.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loadable.sv
`timescale 1ns/1ps
// Loadable instruction memory. After reset it fills itself with NOP, then either
// serves registered fetches or accepts a streamed program load.
module imem_loadable #(
  parameter int            N      = 32,
  parameter int            ADDR_W = 7,
  parameter logic [N-1:0]  NOP    = 32'h8b1f03ff
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd_en,
  output logic [N-1:0]      q,
  output logic              q_valid,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [N-1:0]      ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_count,
  output logic              busy
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {CLEAR, IDLE, LOAD} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [N-1:0]      r_mem [DEPTH];
  logic [N-1:0]      r_q;
  logic              r_q_valid;
  logic              r_ld_done;
  logic [ADDR_W:0]   r_ld_count;

  logic              w_last_addr;
  logic              w_accept;
  logic              w_we;
  logic [N-1:0]      w_wdata;

  // Writes happen only in CLEAR/LOAD and fetches only in IDLE, so the two
  // memory ports are never active together.
  assign w_last_addr = &r_ptr;
  assign w_accept    = (r_state == LOAD) && ld_valid;
  assign w_we        = !reset && ((r_state == CLEAR) || w_accept);
  assign w_wdata     = (r_state == CLEAR) ? NOP : ld_data;

  // NOTE: the array has no reset; the CLEAR sweep initialises it, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_ptr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= CLEAR;
      r_ptr      <= '0;
      r_q        <= NOP;
      r_q_valid  <= 1'b0;
      r_ld_done  <= 1'b0;
      r_ld_count <= '0;
    end else begin
      r_ld_done <= 1'b0;
      case (r_state)
        CLEAR: begin
          r_q       <= NOP;
          r_q_valid <= 1'b0;
          if (w_last_addr) begin
            r_state <= IDLE;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + ADDR_W'(1);
          end
        end
        IDLE: begin
          if (ld_start) begin
            r_state    <= LOAD;
            r_ptr      <= '0;
            r_ld_count <= '0;
            r_q        <= NOP;
            r_q_valid  <= 1'b0;
          end else if (rd_en) begin
            r_q       <= r_mem[addr];
            r_q_valid <= 1'b1;
          end
        end
        LOAD: begin
          r_q       <= NOP;
          r_q_valid <= 1'b0;
          if (ld_valid) begin
            r_ld_count <= r_ld_count + (ADDR_W+1)'(1);
            // The pointer stops at the top word instead of wrapping.
            if (ld_last || w_last_addr) begin
              r_state   <= IDLE;
              r_ld_done <= 1'b1;
            end else begin
              r_ptr <= r_ptr + ADDR_W'(1);
            end
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign q        = r_q;
  assign q_valid  = r_q_valid;
  assign ld_done  = r_ld_done;
  assign ld_count = r_ld_count;
  assign busy     = (r_state != IDLE);
  assign ld_ready = (r_state == LOAD);

endmodule

// File: tb/tb_imem_loadable.sv
`timescale 1ns/1ps
// Randomised bench for imem_loadable: the driver keeps a plain array model of the
// memory and queues expected fetch results; a monitor compares them as fetches complete.
module tb_imem_loadable;

  localparam logic [31:0] NOP_W = 32'h8b1f03ff;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  addr;
  logic        rd_en;
  logic [31:0] q;
  logic        q_valid;
  logic        ld_start;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_done;
  logic [7:0]  ld_count;
  logic        busy;

  imem_loadable dut (
    .clk(clk), .reset(reset), .addr(addr), .rd_en(rd_en), .q(q), .q_valid(q_valid),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_done(ld_done), .ld_count(ld_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: memory contents, load progress, expected fetch results.
  logic [31:0] m_mem [128];
  bit          m_loading = 1'b0;
  int          m_ptr = 0;
  int          m_cnt = 0;
  bit          m_done_now = 1'b0;
  logic [31:0] exp_q [$];
  logic [31:0] words [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: a fetch is presented one edge after an idle cycle with rd_en high.
  initial begin
    forever begin
      @(posedge clk);
      if (!reset && rd_en && !busy && !ld_start) begin
        #1;
        if (exp_q.size() == 0) begin
          check("fetch_unexpected", 1, 0);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("fetch_q", q, e);
          check("fetch_q_valid", q_valid, 1);
        end
      end
    end
  end

  task automatic wait_clear();
    int n = 0;
    while (busy && n < 300) begin
      check("ld_ready_in_clear", ld_ready, 0);
      n++;
      @(negedge clk);
    end
    check("clear_cycles", n, 128);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; rd_en = 0; ld_start = 0; ld_valid = 0; ld_last = 0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 128; i++) m_mem[i] = NOP_W;
    m_loading = 0; m_cnt = 0; m_done_now = 0;
    check("rst_q", q, NOP_W);
    check("rst_q_valid", q_valid, 0);
    check("rst_ld_done", ld_done, 0);
    check("rst_ld_count", ld_count, 0);
    check("rst_busy", busy, 1);
    check("rst_ld_ready", ld_ready, 0);
    reset = 0;
    wait_clear();
  endtask

  task automatic fetch(input int a);
    @(negedge clk);
    addr = 7'(a); rd_en = 1;
    exp_q.push_back(m_mem[a]);
    @(negedge clk);
    rd_en = 0;
  endtask

  task automatic rand_fetch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rd_en = 1'($urandom_range(1));
      addr  = 7'($urandom_range(127));
      if (rd_en) exp_q.push_back(m_mem[addr]);
    end
    @(negedge clk);
    rd_en = 0;
  endtask

  task automatic run_load(input int n, input int last_idx, input logic [7:0] vpat,
                          input int vpat_len, input int gap_pct, input int poke_at);
    int sent = 0;
    int cyc  = 0;
    @(negedge clk);
    rd_en = 0; ld_start = 1;
    @(posedge clk);
    if (!m_loading) begin m_loading = 1; m_ptr = 0; m_cnt = 0; end
    m_done_now = 0;
    @(negedge clk);
    ld_start = 0;
    check("q_after_start", q, NOP_W);
    check("q_valid_after_start", q_valid, 0);
    while (sent < n && cyc < 1000) begin
      if (cyc < vpat_len) ld_valid = vpat[cyc];
      else                ld_valid = ($urandom_range(99) >= gap_pct);
      ld_data  = words[sent];
      ld_last  = (sent == last_idx);
      ld_start = (cyc == poke_at);
      check("ld_ready", ld_ready, m_loading);
      check("ld_done", ld_done, m_done_now);
      @(posedge clk);
      m_done_now = 0;
      if (ld_valid) begin
        if (m_loading) begin
          m_mem[m_ptr] = ld_data;
          m_cnt++;
          if (ld_last || m_ptr == 127) begin m_loading = 0; m_done_now = 1; end
          else m_ptr++;
        end
        sent++;
      end
      cyc++;
      @(negedge clk);
    end
    ld_valid = 0; ld_last = 0; ld_start = 0;
    if (cyc >= 1000) check("load_timeout", 1, 0);
    check("ld_done_tail", ld_done, m_done_now);
    check("ld_count", ld_count, m_cnt);
    m_done_now = 0;
    @(negedge clk);
    check("ld_done_after", ld_done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    addr = '0; rd_en = 0; ld_start = 0; ld_valid = 0; ld_data = '0; ld_last = 0; reset = 1;

    // Reset, clear sweep, fetch of a cleared word.
    do_reset();
    fetch(5);

    // Three-word program terminated by ld_last.
    words = '{32'hf8000001, 32'hf8008002, 32'hb400001f};
    run_load(3, 2, 8'h00, 0, 0, -1);
    fetch(2);
    fetch(3);

    // Fetch then stall with a moving address: q must hold.
    fetch(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      addr = 7'($urandom_range(127));
      rd_en = 0;
      @(negedge clk);
      check("hold_q", q, m_mem[1]);
      check("hold_q_valid", q_valid, 1);
    end

    // Gapped load with ld_start pulsed mid-load.
    words = '{32'h11110000, 32'h22220000};
    run_load(2, 1, 8'b0000_1001, 4, 0, 1);
    fetch(0);
    fetch(1);
    fetch(2);

    // Overlong load without ld_last: stops at the top word.
    words = {};
    for (int i = 0; i < 130; i++) words.push_back($urandom);
    run_load(130, -1, 8'h00, 0, 20, -1);
    check("ld_ready_after_full", ld_ready, 0);
    fetch(127);
    fetch(0);

    // Randomised loads interleaved with random fetches.
    repeat (4) begin
      int n;
      n = $urandom_range(1, 20);
      words = {};
      for (int i = 0; i < n; i++) words.push_back($urandom);
      run_load(n, $urandom_range(0, n - 1), 8'h00, 0, 30, -1);
      rand_fetch(40);
    end

    // Reset in the middle of a load.
    words = '{32'hdead0001, 32'hdead0002};
    run_load(2, -1, 8'h00, 0, 0, -1);
    do_reset();
    fetch(0);
    fetch(1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
